// File: rtl/ext_pkg.sv
// Shared size encodings and helpers for the load-data extractor.
package ext_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    function automatic int sz_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/ext_align_core.sv
// Combinational field extract, sign/zero extend and alignment check.
module ext_align_core
    import ext_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW/8)
) (
    input  logic [DW-1:0]   data_i,
    input  logic [OFFW-1:0] off_i,
    input  logic [1:0]      size_i,
    input  logic            sext_i,
    output logic [DW-1:0]   data_o,
    output logic            err_o
);

    localparam int LW = $clog2(DW);

    logic [DW-1:0] sh;
    logic [DW-1:0] res;
    logic [LW-1:0] msb;
    logic          sgn;
    logic          illegal;
    logic          misal;
    int            szbits;

    always_comb begin
        szbits  = sz_bytes(size_i) * 8;
        sh      = data_i >> {off_i, 3'b000};
        illegal = szbits > DW;
        misal   = (off_i & OFFW'(sz_bytes(size_i) - 1)) != '0;
        // Clamp the sign index so an illegal size never reads past the bus.
        msb     = illegal ? '0 : LW'(szbits - 1);
        sgn     = sext_i & sh[msb];
        res     = '0;
        for (int i = 0; i < DW; i++) begin
            res[i] = (i < szbits) ? sh[i] : sgn;
        end
        err_o  = illegal | misal;
        data_o = err_o ? '0 : res;
    end

endmodule

// File: rtl/ext_align_pipe.sv
// Registered extractor with 2-entry skid buffer and saturating error count.
module ext_align_pipe
    import ext_pkg::*;
#(
    parameter int DW   = 32,
    parameter int OFFW = $clog2(DW/8),
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    input  logic [OFFW-1:0] in_off,
    input  logic [1:0]      in_size,
    input  logic            in_sext,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_err,
    output logic [CNTW-1:0] err_cnt
);

    logic [DW-1:0]   core_data;
    logic            core_err;

    logic            main_v_q, main_v_d;
    logic [DW-1:0]   main_data_q, main_data_d;
    logic            main_err_q, main_err_d;
    logic            skid_v_q, skid_v_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic            skid_err_q, skid_err_d;
    logic            rdy_q, rdy_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            in_fire;
    logic            out_fire;

    ext_align_core #(
        .DW   (DW),
        .OFFW (OFFW)
    ) u_core (
        .data_i (in_data),
        .off_i  (in_off),
        .size_i (in_size),
        .sext_i (in_sext),
        .data_o (core_data),
        .err_o  (core_err)
    );

    always_comb begin
        main_v_d    = main_v_q;
        main_data_d = main_data_q;
        main_err_d  = main_err_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        skid_err_d  = skid_err_q;
        cnt_d       = cnt_q;
        in_fire     = in_valid & rdy_q;
        out_fire    = main_v_q & out_ready;

        if (!main_v_q || out_fire) begin
            if (skid_v_q) begin
                main_v_d    = 1'b1;
                main_data_d = skid_data_q;
                main_err_d  = skid_err_q;
                skid_v_d    = 1'b0;
            end else begin
                main_v_d = in_fire;
                if (in_fire) begin
                    main_data_d = core_data;
                    main_err_d  = core_err;
                end
            end
        end else if (in_fire) begin
            skid_v_d    = 1'b1;
            skid_data_d = core_data;
            skid_err_d  = core_err;
        end

        rdy_d = !skid_v_d;

        if (in_fire && core_err && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_v_q    <= 1'b0;
            main_data_q <= '0;
            main_err_q  <= 1'b0;
            skid_v_q    <= 1'b0;
            skid_data_q <= '0;
            skid_err_q  <= 1'b0;
            rdy_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            main_v_q    <= main_v_d;
            main_data_q <= main_data_d;
            main_err_q  <= main_err_d;
            skid_v_q    <= skid_v_d;
            skid_data_q <= skid_data_d;
            skid_err_q  <= skid_err_d;
            rdy_q       <= rdy_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign out_err   = main_err_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_ext_align_pipe.sv
// Randomized and directed bench for ext_align_pipe against a queue model.
module tb_ext_align_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_off;
    logic [1:0]  in_size;
    logic        in_sext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_err;
    logic [7:0]  err_cnt;

    logic        v64;
    logic        rdy64;
    logic [63:0] d64;
    logic [2:0]  off64;
    logic [1:0]  size64;
    logic        sext64;
    logic        ov64;
    logic [63:0] od64;
    logic        oe64;
    logic [7:0]  cnt64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        bit          e;
    } beat_t;

    beat_t q[$];
    int    ecnt;
    bit    rdy_exp;

    ext_align_pipe #(.DW(32), .CNTW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_off    (in_off),
        .in_size   (in_size),
        .in_sext   (in_sext),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    ext_align_pipe #(.DW(64), .CNTW(8)) dut64 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v64),
        .in_ready  (rdy64),
        .in_data   (d64),
        .in_off    (off64),
        .in_size   (size64),
        .in_sext   (sext64),
        .out_valid (ov64),
        .out_ready (1'b1),
        .out_data  (od64),
        .out_err   (oe64),
        .err_cnt   (cnt64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask

    // Field = bytes [off, off+nb) of d, widened by its top bit when sx.
    function automatic void ref_ext(input logic [31:0] d, input int off,
                                    input int size, input bit sx,
                                    output logic [31:0] r, output bit e);
        longint unsigned v, m, f;
        int nb;
        nb = 1 << size;
        e  = (nb > 4) || (off % nb != 0);
        r  = '0;
        if (e) return;
        v = 64'(d) >> (8 * off);
        m = (64'd1 << (8 * nb)) - 1;
        f = v & m;
        if (sx && f[8*nb-1]) f = f | ~m;
        r = f[31:0];
    endfunction

    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_err_cnt", 64'(err_cnt), 64'd0);
            q.delete();
            ecnt    = 0;
            rdy_exp = 1'b0;
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("in_ready", 64'(in_ready), 64'(rdy_exp));
            chk("err_cnt", 64'(err_cnt), 64'(ecnt));
            if (q.size() > 0) begin
                chk("out_data", 64'(out_data), 64'(q[0].d));
                chk("out_err", 64'(out_err), 64'(q[0].e));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && rdy_exp) begin
                ref_ext(in_data, int'(in_off), int'(in_size), in_sext,
                        b.d, b.e);
                q.push_back(b);
                if (b.e && ecnt < 255) ecnt++;
            end
            rdy_exp = q.size() < 2;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [1:0] off, input logic [1:0] sz,
                         input logic sx);
        in_valid = v;
        in_data  = d;
        in_off   = off;
        in_size  = sz;
        in_sext  = sx;
    endtask

    initial begin
        logic [31:0] r;
        bit          e;
        int          nout;

        rst       = 1'b0;
        out_ready = 1'b1;
        v64       = 1'b0;
        d64       = '0;
        off64     = '0;
        size64    = '0;
        sext64    = 1'b0;
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);

        ref_ext(32'h8899_AABB, 2, 0, 1'b1, r, e);
        chk("model_b_sx", {31'd0, e, r}, {31'd0, 1'b0, 32'hFFFF_FF99});
        ref_ext(32'h8899_AABB, 2, 0, 1'b0, r, e);
        chk("model_b_zx", {31'd0, e, r}, {31'd0, 1'b0, 32'h0000_0099});
        ref_ext(32'h8899_AABB, 2, 1, 1'b1, r, e);
        chk("model_h_sx", {31'd0, e, r}, {31'd0, 1'b0, 32'hFFFF_8899});
        ref_ext(32'h8899_AABB, 1, 1, 1'b1, r, e);
        chk("model_misal", {31'd0, e, r}, {31'd0, 1'b1, 32'd0});
        ref_ext(32'h8899_AABB, 0, 3, 1'b0, r, e);
        chk("model_illegal", {31'd0, e, r}, {31'd0, 1'b1, 32'd0});

        repeat (3) step();
        rst = 1'b1;
        step();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        drive(1'b1, 32'h8899_AABB, 2'd2, 2'b00, 1'b1);
        step();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_data", 64'(out_data), 64'hFFFF_FF99);
        chk("t1_err", 64'(out_err), 64'd0);
        drive(1'b1, 32'h8899_AABB, 2'd2, 2'b00, 1'b0);
        step();
        chk("t2_zx", 64'(out_data), 64'h0000_0099);
        drive(1'b1, 32'h8899_AABB, 2'd2, 2'b01, 1'b1);
        step();
        chk("t2_half", 64'(out_data), 64'hFFFF_8899);
        drive(1'b1, 32'h8899_AABB, 2'd1, 2'b01, 1'b1);
        step();
        chk("t3_misal_err", 64'(out_err), 64'd1);
        chk("t3_misal_data", 64'(out_data), 64'd0);
        chk("t3_cnt1", 64'(err_cnt), 64'd1);
        drive(1'b1, 32'h8899_AABB, 2'd0, 2'b11, 1'b0);
        step();
        chk("t3_illegal", 64'(out_err), 64'd1);
        chk("t3_cnt2", 64'(err_cnt), 64'd2);
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        step();

        out_ready = 1'b0;
        drive(1'b1, 32'h1122_3344, 2'd0, 2'b10, 1'b0);
        step();
        drive(1'b1, 32'h0000_00F0, 2'd0, 2'b00, 1'b1);
        step();
        drive(1'b1, 32'h1234_5678, 2'd2, 2'b01, 1'b0);
        repeat (3) begin
            step();
            chk("bp_ready_low", 64'(in_ready), 64'd0);
            chk("bp_hold_a", 64'(out_data), 64'h1122_3344);
        end
        out_ready = 1'b1;
        step();
        chk("bp_b", 64'(out_data), 64'hFFFF_FFF0);
        step();
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        chk("bp_c", 64'(out_data), 64'h0000_1234);
        step();
        step();
        chk("bp_empty", 64'(out_valid), 64'd0);

        nout = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, $urandom, 2'd0, 2'b10, 1'($urandom_range(0, 1)));
            step();
            chk("tp_ready", 64'(in_ready), 64'd1);
            if (out_valid) nout++;
        end
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        chk("tp_count", 64'(nout), 64'd16);
        step();

        drive(1'b1, 32'hDEAD_BEEF, 2'd1, 2'b01, 1'b0);
        repeat (300) step();
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        step();
        chk("sat_255", 64'(err_cnt), 64'd255);

        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_5555, 2'd0, 2'b10, 1'b0);
        step();
        drive(1'b1, 32'h5555_AAAA, 2'd0, 2'b10, 1'b0);
        step();
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        chk("full_ready_low", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_err_cnt", 64'(err_cnt), 64'd0);
        repeat (3) step();
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (4) step();
        chk("arst_no_stale", 64'(out_valid), 64'd0);

        for (int i = 0; i < 2000; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drive(1'b0, '0, 2'd0, 2'd0, 1'b0);
        out_ready = 1'b1;
        repeat (3) step();

        v64    = 1'b1;
        d64    = 64'h8000_0000_0000_0001;
        off64  = 3'd0;
        size64 = 2'b11;
        sext64 = 1'b1;
        step();
        chk("w64_valid", 64'(ov64), 64'd1);
        chk("w64_pass", od64, 64'h8000_0000_0000_0001);
        chk("w64_err", 64'(oe64), 64'd0);
        d64    = 64'h8000_0000_0000_0000;
        off64  = 3'd4;
        size64 = 2'b10;
        step();
        chk("w64_word_sx", od64, 64'hFFFF_FFFF_8000_0000);
        off64  = 3'd2;
        step();
        chk("w64_misal", 64'(oe64), 64'd1);
        chk("w64_cnt", 64'(cnt64), 64'd1);
        v64 = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
